// File: rtl/axis_swizzle_pipe.sv
// -----------------------------------------------------------------------------
// axis_swizzle_pipe
//
// AXI-Stream group-reversal stage. Each beat is split into 2^k equal groups,
// where k is the packet's reversal mode, and the group order is reversed.
// Mode 0 is identity and mode log2(DATA_W) is full bit reversal. The mode is
// captured on the first beat of every packet and held for the rest of it.
// Modes above log2(DATA_W) pass data through unchanged and raise a sticky
// error flag. The output is registered, with a skid register behind it so
// that S_AXIS_tready can be a plain flop.
//
// Optional feature macro: SWZ_PKT_CNT_EN
//   defined   : pkt_cnt counts output handshakes carrying tlast (wraps at 16 bits)
//   undefined : pkt_cnt is tied to zero and no counter is built
//
// Ports
//   S_APB_aclk       clock
//   S_APB_aresetn    synchronous active-low reset
//   S_AXIS_*         input stream (tdata/tvalid/tkeep/tlast/tready)
//   swz_mode         requested reversal mode, sampled on first beat of packet
//   M_AXIS_*         output stream (tdata/tvalid/tkeep/tlast/tready)
//   err_mode         sticky flag: an illegal mode was used since reset
//   pkt_cnt          completed-packet count (see macro above)
// -----------------------------------------------------------------------------
module axis_swizzle_pipe #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = DATA_W / 8,
    parameter int MODE_W = 3
) (
    input  logic              S_APB_aclk,
    input  logic              S_APB_aresetn,
    input  logic [DATA_W-1:0] S_AXIS_tdata,
    input  logic              S_AXIS_tvalid,
    input  logic [KEEP_W-1:0] S_AXIS_tkeep,
    input  logic              S_AXIS_tlast,
    output logic              S_AXIS_tready,
    input  logic [MODE_W-1:0] swz_mode,
    output logic [DATA_W-1:0] M_AXIS_tdata,
    output logic              M_AXIS_tvalid,
    output logic [KEEP_W-1:0] M_AXIS_tkeep,
    output logic              M_AXIS_tlast,
    input  logic              M_AXIS_tready,
    output logic              err_mode,
    output logic [15:0]       pkt_cnt
);

    localparam int L = $clog2(DATA_W);

    // Reversing the order of 2^k groups is the same as flipping the top k bits
    // of every bit index, so each bit moves to (index XOR flip).
    function automatic logic [DATA_W-1:0] swizzle(input logic [DATA_W-1:0] d,
                                                  input logic [MODE_W-1:0] k);
        logic [DATA_W-1:0] r;
        logic [L-1:0]      flip;
        logic [L-1:0]      src;
        logic [L-1:0]      dst;
        r = d;
        if (k != '0 && k <= MODE_W'(L)) begin
            flip = ~({L{1'b1}} >> k);
            for (int b = 0; b < DATA_W; b++) begin
                src    = L'(b);
                dst    = src ^ flip;
                r[dst] = d[src];
            end
        end
        return r;
    endfunction

    function automatic logic mode_illegal(input logic [MODE_W-1:0] k);
        return k > MODE_W'(L);
    endfunction

    logic              in_ready_p1;
    logic              first_beat;
    logic [MODE_W-1:0] pkt_mode;
    logic              err_r;

    logic [MODE_W-1:0] eff_mode_p0;
    logic [DATA_W-1:0] swz_data_p0;
    logic              acc_p0;
    logic              hs_p1;

    logic              out_vld_p1;
    logic [DATA_W-1:0] out_data_p1;
    logic [KEEP_W-1:0] out_keep_p1;
    logic              out_last_p1;

    logic              skid_vld_p1;
    logic [DATA_W-1:0] skid_data_p1;
    logic [KEEP_W-1:0] skid_keep_p1;
    logic              skid_last_p1;

    // ---- stage p0: accept and transform (combinational, ahead of registers)
    always_comb begin
        acc_p0      = S_AXIS_tvalid & in_ready_p1;
        eff_mode_p0 = first_beat ? swz_mode : pkt_mode;
        swz_data_p0 = swizzle(S_AXIS_tdata, eff_mode_p0);
        hs_p1       = out_vld_p1 & M_AXIS_tready;
    end

    // ---- stage p1: output register and skid register
    always_ff @(posedge S_APB_aclk) begin
        if (!S_APB_aresetn) begin
            in_ready_p1 <= 1'b0;
            first_beat  <= 1'b1;
            pkt_mode    <= '0;
            err_r       <= 1'b0;
            out_vld_p1  <= 1'b0;
            out_data_p1 <= '0;
            out_keep_p1 <= '0;
            out_last_p1 <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else begin
            // Ready mirrors skid emptiness; overridden below when the skid
            // changes state this cycle.
            in_ready_p1 <= ~skid_vld_p1;

            if (acc_p0) begin
                first_beat <= S_AXIS_tlast;
                if (first_beat) begin
                    pkt_mode <= swz_mode;
                end
                if (mode_illegal(eff_mode_p0)) begin
                    err_r <= 1'b1;
                end
            end

            if (!out_vld_p1 || hs_p1) begin
                // Output register is free this cycle. Skid has priority to
                // keep beat order; with the skid full, input is not ready.
                if (skid_vld_p1) begin
                    out_vld_p1  <= 1'b1;
                    out_data_p1 <= skid_data_p1;
                    out_keep_p1 <= skid_keep_p1;
                    out_last_p1 <= skid_last_p1;
                    skid_vld_p1 <= 1'b0;
                    in_ready_p1 <= 1'b1;
                end else if (acc_p0) begin
                    out_vld_p1  <= 1'b1;
                    out_data_p1 <= swz_data_p0;
                    out_keep_p1 <= S_AXIS_tkeep;
                    out_last_p1 <= S_AXIS_tlast;
                end else begin
                    out_vld_p1  <= 1'b0;
                end
            end else if (acc_p0) begin
                // Output stalled: park the beat and stop accepting.
                skid_vld_p1  <= 1'b1;
                skid_data_p1 <= swz_data_p0;
                skid_keep_p1 <= S_AXIS_tkeep;
                skid_last_p1 <= S_AXIS_tlast;
                in_ready_p1  <= 1'b0;
            end
        end
    end

    assign S_AXIS_tready = in_ready_p1;
    assign M_AXIS_tvalid = out_vld_p1;
    assign M_AXIS_tdata  = out_data_p1;
    assign M_AXIS_tkeep  = out_keep_p1;
    assign M_AXIS_tlast  = out_last_p1;
    assign err_mode      = err_r;

`ifdef SWZ_PKT_CNT_EN
    logic [15:0] pkt_cnt_r;

    always_ff @(posedge S_APB_aclk) begin
        if (!S_APB_aresetn) begin
            pkt_cnt_r <= 16'd0;
        end else if (hs_p1 && out_last_p1) begin
            pkt_cnt_r <= pkt_cnt_r + 16'd1;
        end
    end

    assign pkt_cnt = pkt_cnt_r;
`else
    assign pkt_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_axis_swizzle_pipe.sv
// -----------------------------------------------------------------------------
// tb_axis_swizzle_pipe
//
// Scoreboard bench for axis_swizzle_pipe. An 8-bit instance carries the main
// traffic: directed vectors, mode latching, backpressure, reset mid-packet and
// randomized packets. Expected beats are queued at input accept and checked by
// a monitor at every output handshake. A 16-bit instance covers wide-word
// reversal and the illegal-mode flag.
// -----------------------------------------------------------------------------
module tb_axis_swizzle_pipe;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic [0:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tready;
    logic [2:0]  swz_mode;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic [0:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tready;
    logic        err_mode;
    logic [15:0] pkt_cnt;

    logic [15:0] h_s_tdata;
    logic        h_s_tvalid;
    logic [1:0]  h_s_tkeep;
    logic        h_s_tlast;
    logic        h_s_tready;
    logic [2:0]  h_mode;
    logic [15:0] h_m_tdata;
    logic        h_m_tvalid;
    logic [1:0]  h_m_tkeep;
    logic        h_m_tlast;
    logic        h_m_tready;
    logic        h_err;
    logic [15:0] h_pkt_cnt;
    assign h_m_tready = 1'b1;

    axis_swizzle_pipe #(.DATA_W(8), .MODE_W(3)) dut8 (
        .S_APB_aclk(clk), .S_APB_aresetn(rstn),
        .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tkeep(s_tkeep),
        .S_AXIS_tlast(s_tlast), .S_AXIS_tready(s_tready), .swz_mode(swz_mode),
        .M_AXIS_tdata(m_tdata), .M_AXIS_tvalid(m_tvalid), .M_AXIS_tkeep(m_tkeep),
        .M_AXIS_tlast(m_tlast), .M_AXIS_tready(m_tready),
        .err_mode(err_mode), .pkt_cnt(pkt_cnt)
    );

    axis_swizzle_pipe #(.DATA_W(16), .MODE_W(3)) dut16 (
        .S_APB_aclk(clk), .S_APB_aresetn(rstn),
        .S_AXIS_tdata(h_s_tdata), .S_AXIS_tvalid(h_s_tvalid), .S_AXIS_tkeep(h_s_tkeep),
        .S_AXIS_tlast(h_s_tlast), .S_AXIS_tready(h_s_tready), .swz_mode(h_mode),
        .M_AXIS_tdata(h_m_tdata), .M_AXIS_tvalid(h_m_tvalid), .M_AXIS_tkeep(h_m_tkeep),
        .M_AXIS_tlast(h_m_tlast), .M_AXIS_tready(h_m_tready),
        .err_mode(h_err), .pkt_cnt(h_pkt_cnt)
    );

    typedef struct {
        logic [7:0] d;
        logic [0:0] k;
        logic       l;
    } beat_t;

    beat_t sb_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    ready_mode = 0;   // 0: always ready, 1: never, 2: 1,0,0 pattern, 3: random
    bit    exp_err = 1'b0;
    int    exp_pkt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: split into 2^k groups of w/2^k bits and reverse group order.
    function automatic logic [63:0] ref_swz(input logic [63:0] d, input int k, input int w);
        int          lg, n, g;
        logic [63:0] r, grp, m;
        lg = $clog2(w);
        if (k == 0 || k > lg) return d & ((64'd1 << w) - 64'd1);
        n = 1 << k;
        g = w / n;
        m = (64'd1 << g) - 64'd1;
        r = '0;
        for (int i = 0; i < n; i++) begin
            grp = (d >> (i * g)) & m;
            r   = r | (grp << ((n - 1 - i) * g));
        end
        return r;
    endfunction

    // Output-side ready generator; changes 1 time unit after the rising edge.
    initial begin
        int ph;
        ph = 0;
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = 1'b0;
                2:       begin m_tready = (ph == 0); ph = (ph + 1) % 3; end
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: samples on the falling edge, for the upcoming rising edge.
    initial begin
        bit    prev_rstn, stall;
        int    outst;
        beat_t e, held;
        prev_rstn = 1'b0;
        stall     = 1'b0;
        outst     = 0;
        forever begin
            @(negedge clk);
            if (!prev_rstn) begin
                sb_q.delete();
                outst   = 0;
                exp_pkt = 0;
                chk("s_tready_after_reset_edge", s_tready, 0);
            end else begin
                chk("s_tready_vs_fill", s_tready, (outst < 2));
            end
            if (rstn) begin
                if (stall) begin
                    chk("hold_valid", m_tvalid, 1);
                    chk("hold_data", m_tdata, held.d);
                    chk("hold_keep", m_tkeep, held.k);
                    chk("hold_last", m_tlast, held.l);
                end
                if (m_tvalid && m_tready) begin
                    chk("beat_expected", (sb_q.size() != 0), 1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        chk("out_data", m_tdata, e.d);
                        chk("out_keep", m_tkeep, e.k);
                        chk("out_last", m_tlast, e.l);
                    end
                    if (m_tlast) exp_pkt++;
                end
                outst = outst + int'(s_tvalid && s_tready) - int'(m_tvalid && m_tready);
                stall = m_tvalid && !m_tready;
                held  = '{m_tdata, m_tkeep, m_tlast};
            end else begin
                stall = 1'b0;
            end
            prev_rstn = rstn;
        end
    end

    // Drives one beat (called just after a rising edge) and queues its
    // expected output once the DUT is seen ready for the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic [0:0] k, input logic l,
                             input logic [2:0] m, input logic [7:0] exp);
        int    n;
        beat_t e;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        swz_mode = m;
        s_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_tready) begin
                e = '{exp, k, l};
                sb_q.push_back(e);
                break;
            end
            n++;
            if (n >= 100) begin
                chk("accept_timeout", s_tready, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        swz_mode = 3'($urandom_range(0, 7));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", sb_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_pkt_cnt(input string name);
        logic [15:0] e;
`ifdef SWZ_PKT_CNT_EN
        e = 16'(exp_pkt);
`else
        e = 16'd0;
`endif
        chk(name, pkt_cnt, e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          len, pm;
        logic [7:0]  d8;
        logic [0:0]  k1;
        logic [63:0] r64;

        s_tdata = '0; s_tvalid = 1'b0; s_tkeep = '0; s_tlast = 1'b0; swz_mode = '0;
        h_s_tdata = '0; h_s_tvalid = 1'b0; h_s_tkeep = '0; h_s_tlast = 1'b0; h_mode = '0;

        // Reset state
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tkeep", m_tkeep, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_err_mode", err_mode, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_s_tready", s_tready, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("s_tready_first_cycle", s_tready, 1);
        @(posedge clk);
        #1;

        // Directed single-beat vectors, output one cycle after accept
        ready_mode = 0;
        send_beat(8'hA5, 1'b1, 1'b1, 3'd1, 8'h5A);
        @(negedge clk);
        chk("latency_1cycle", m_tvalid, 1);
        @(posedge clk);
        #1;
        send_beat(8'hB4, 1'b1, 1'b1, 3'd2, 8'h1E);
        send_beat(8'h01, 1'b1, 1'b1, 3'd3, 8'h80);
        send_beat(8'h3C, 1'b0, 1'b1, 3'd0, 8'h3C);

        // Mode latched on first beat; later swz_mode changes ignored
        send_beat(8'h01, 1'b1, 1'b0, 3'd3, 8'h80);
        send_beat(8'h01, 1'b1, 1'b0, 3'd1, 8'h80);
        send_beat(8'h01, 1'b1, 1'b0, 3'd1, 8'h80);
        send_beat(8'h01, 1'b1, 1'b1, 3'd1, 8'h80);
        send_beat(8'h01, 1'b1, 1'b1, 3'd1, 8'h10);
        drain();
        chk("err_after_legal", err_mode, 0);
        chk_pkt_cnt("pkt_cnt_directed");

        // Backpressure with a 1,0,0 ready pattern
        ready_mode = 2;
        for (int i = 1; i <= 8; i++) begin
            send_beat(8'(i), 1'b1, (i == 8), 3'd0, 8'(i));
        end
        drain();

        // Randomized packets with random ready and idle gaps
        ready_mode = 3;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 4);
            pm  = $urandom_range(0, 7);
            if (pm > 3) exp_err = 1'b1;
            for (int b = 0; b < len; b++) begin
                d8  = 8'($urandom);
                k1  = 1'($urandom_range(0, 1));
                r64 = ref_swz({56'd0, d8}, pm, 8);
                send_beat(d8, k1, (b == len - 1), (b == 0) ? 3'(pm) : 3'($urandom_range(0, 7)), r64[7:0]);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        drain();
        chk("err_after_random", err_mode, exp_err);
        chk_pkt_cnt("pkt_cnt_random");

        // Reset mid-packet with output stalled and skid full
        ready_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        send_beat(8'h11, 1'b1, 1'b0, 3'd2, 8'h44);
        send_beat(8'h22, 1'b1, 1'b0, 3'd2, 8'h88);
        rstn    = 1'b0;
        exp_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("tvalid_after_midpkt_reset", m_tvalid, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        send_beat(8'h01, 1'b1, 1'b1, 3'd3, 8'h80);
        send_beat(8'h01, 1'b1, 1'b1, 3'd1, 8'h10);
        send_beat(8'hA5, 1'b1, 1'b1, 3'd0, 8'hA5);
        drain();
        chk("err_cleared_by_reset", err_mode, 0);
        chk_pkt_cnt("pkt_cnt_three_pkts");

        // 16-bit instance: full reversal and sticky illegal mode
        h_s_tdata = 16'h0001; h_s_tkeep = 2'b11; h_s_tlast = 1'b1; h_mode = 3'd4; h_s_tvalid = 1'b1;
        @(negedge clk);
        chk("w16_ready", h_s_tready, 1);
        @(posedge clk);
        #1 h_s_tvalid = 1'b0;
        @(negedge clk);
        chk("w16_m4_valid", h_m_tvalid, 1);
        chk("w16_m4_data", h_m_tdata, 16'h8000);
        chk("w16_m4_err", h_err, 0);
        @(posedge clk);
        #1;
        h_s_tdata = 16'h1234; h_s_tkeep = 2'b01; h_mode = 3'd5; h_s_tvalid = 1'b1;
        @(posedge clk);
        #1 h_s_tvalid = 1'b0;
        @(negedge clk);
        chk("w16_m5_data", h_m_tdata, 16'h1234);
        chk("w16_m5_keep", h_m_tkeep, 2'b01);
        chk("w16_m5_err", h_err, 1);
        @(posedge clk);
        #1;
        h_s_tdata = 16'h00F1; h_s_tkeep = 2'b11; h_mode = 3'd0; h_s_tvalid = 1'b1;
        @(posedge clk);
        #1 h_s_tvalid = 1'b0;
        @(negedge clk);
        chk("w16_m0_data", h_m_tdata, 16'h00F1);
        chk("w16_err_sticky", h_err, 1);
        chk("w8_err_unaffected", err_mode, 0);

        repeat (2) @(posedge clk);
        #1;
        chk_pkt_cnt("pkt_cnt_final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
